// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: round-robin sequencer sharing one SPI transfer engine between NUM_REQ requesters.
// Define SPI_ARB_TIMEOUT_EN to build the WAIT-state watchdog (TIMEOUT_CYCLES); otherwise err is tied low.
module spi_xfer_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*32-1:0] wdata,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    ack,
    output logic [31:0]           rdata,
    output logic                  err,
    output logic                  spi_go_n,
    output logic [31:0]           spi_wdata,
    input  logic [31:0]           spi_rdata,
    input  logic                  spi_done
);
    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [2:0] {IDLE, ARB, LAUNCH, WAIT, DONE, GAP} state_t;

    state_t           state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] sel_idx;
    logic [PTR_W-1:0] cand;
    logic             launch_cnt;
    logic [3:0]       gap_cnt;
    logic             timeout_hit;
    logic [31:0]      wdata_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign wdata_arr[i] = wdata[32*i +: 32];
    end

    // Scan from farthest to nearest so the first asserted req after rr_ptr wins.
    always_comb begin
        sel_idx = rr_ptr;
        cand    = rr_ptr;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (req[cand]) sel_idx = cand;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rr_ptr     <= PTR_W'(NUM_REQ-1);
            gnt        <= '0;
            ack        <= '0;
            rdata      <= '0;
            spi_go_n   <= 1'b1;
            spi_wdata  <= '0;
            launch_cnt <= 1'b0;
            gap_cnt    <= '0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (|req) state <= ARB;
                end
                ARB: begin
                    if (|req) begin
                        gnt        <= NUM_REQ'(1) << sel_idx;
                        spi_wdata  <= wdata_arr[sel_idx];
                        rr_ptr     <= sel_idx;
                        spi_go_n   <= 1'b0;
                        launch_cnt <= 1'b0;
                        state      <= LAUNCH;
                    end else begin
                        state <= IDLE;
                    end
                end
                LAUNCH: begin
                    if (launch_cnt) begin
                        spi_go_n <= 1'b1;
                        state    <= WAIT;
                    end else begin
                        launch_cnt <= 1'b1;
                    end
                end
                WAIT: begin
                    // spi_done takes priority over a coincident watchdog expiry.
                    if (spi_done) begin
                        rdata <= spi_rdata;
                        ack   <= gnt;
                        state <= DONE;
                    end else if (timeout_hit) begin
                        rdata <= '0;
                        ack   <= gnt;
                        state <= DONE;
                    end
                end
                DONE: begin
                    gnt     <= '0;
                    gap_cnt <= '0;
                    state   <= GAP;
                end
                GAP: begin
                    if (gap_cnt == 4'(GAP_CYCLES-1)) state <= IDLE;
                    else                              gap_cnt <= gap_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES+1);

    logic [TO_W-1:0] wait_cnt;

    assign timeout_hit = (wait_cnt == TO_W'(TIMEOUT_CYCLES-1));

    // Counter is held at zero outside WAIT, so it restarts on every WAIT entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            if (state != WAIT)                  wait_cnt <= '0;
            else if (!spi_done && !timeout_hit) wait_cnt <= wait_cnt + 1'b1;
            err <= (state == WAIT) && !spi_done && timeout_hit;
        end
    end
`else
    // No watchdog: legal TIMEOUT_CYCLES is at least 1, so WAIT only exits on spi_done.
    assign timeout_hit = (TIMEOUT_CYCLES < 1);
    assign err         = 1'b0;
`endif

endmodule

// File: doc/spi_xfer_arbiter.md
Name: spi_xfer_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one SPI byte-serial transfer engine between NUM_REQ requesters.
- Each requester posts a 32-bit word. The arbiter grants one requester, latches its word, and launches the engine with an active-low go strobe.
- It then waits for the engine's pack-ready pulse and returns the 32-bit read word with a one-cycle ack.
- Sits between the bus-side clients (Avalon slave logic, FIFO readers) and the SPI core.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GAP_CYCLES, 4, idle cycles enforced after each transfer before the next grant (1..15); gives chip select time to deassert.
- TIMEOUT_CYCLES, 1024, WAIT-state watchdog limit in clk cycles (used only with SPI_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-requester transfer request, level; held until own ack
- wdata  in  NUM_REQ*32  per-requester write words, requester i at [32*i+31:32*i]
- gnt  out  NUM_REQ  one-hot grant, held from ARB through DONE
- ack  out  NUM_REQ  one-cycle completion pulse to the granted requester
- rdata  out  32  read word, valid in the ack cycle, held until next ack
- err  out  1  qualifies ack: 1 = transfer timed out
- spi_go_n  out  1  active-low launch strobe to the SPI core
- spi_wdata  out  32  word to the core, stable from LAUNCH until done
- spi_rdata  in  32  read word from the core
- spi_done  in  1  one-cycle pack-ready pulse from the core

Behaviour:
- Reset values: gnt=0, ack=0, rdata=0, err=0, spi_go_n=1, spi_wdata=0, rr pointer=NUM_REQ-1, state=IDLE, counters=0.
- Reset mid-transfer: all outputs return to reset values immediately. Any engine activity in flight is abandoned, and a later spi_done is ignored (arrives in IDLE).
- FSM states: IDLE, ARB, LAUNCH, WAIT, DONE, GAP.
- IDLE: when |req=1, go to ARB next cycle. Otherwise stay.
- ARB (1 cycle):
  - Select the first asserted req searching from rr_ptr+1 upward, with modulo-NUM_REQ wrap.
  - Register gnt one-hot, set spi_wdata to the selected wdata slice, and update rr_ptr to the selected index.
  - If req has dropped to 0 by this cycle, return to IDLE with no grant.
- LAUNCH (2 cycles): spi_go_n=0 for exactly 2 cycles, then 1. Then go to WAIT.
- WAIT:
  - On spi_done=1: capture spi_rdata into rdata, go to DONE.
  - spi_done in any state other than WAIT is ignored.
- DONE (1 cycle): ack[granted]=1, err=0. gnt clears at the end of this cycle. Go to GAP.
- GAP: count GAP_CYCLES cycles with gnt=0, then go to IDLE. A request pending at the end of GAP reaches ARB 1 cycle later.
- Latency: from ARB to spi_go_n falling is 1 cycle. From spi_done to ack is 1 cycle.
- Minimum req-to-ack latency from IDLE is 4 cycles plus engine time.
- Fairness:
  - With all requesters asserting continuously, the grant order is 0,1,...,NUM_REQ-1,0,...
  - No requester is granted twice while another requester is waiting.
- Requester rules:
  - wdata must be stable while req=1 and gnt=0. It is sampled only in ARB.
  - Dropping req after grant does not abort: the transfer completes and ack still pulses.
- Simultaneous spi_done and timeout expiry in the same cycle: spi_done wins, err=0.

Optional Feature:
- Macro SPI_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT and clears on WAIT entry.
  - If it reaches TIMEOUT_CYCLES without spi_done, go to DONE with rdata=0 and err=1 during the ack cycle, then GAP as normal.
  - A late spi_done arriving after this is ignored.
- Undefined: no counter is built, WAIT waits indefinitely, and err is tied to 0.

Test Plan:
- Single requester: req[0]=1, wdata0=0xA5A5_1234; engine model returns 0xDEAD_BEEF after 70 cycles.
  - spi_go_n low 2 cycles starting 1 cycle after ARB, spi_wdata=0xA5A51234.
  - ack[0] 1 cycle after spi_done, rdata=0xDEADBEEF, err=0.
- Contention: req=4'b1111 held for 8 transfers, distinct wdata per requester.
  - Grant order 0,1,2,3,0,1,2,3.
  - Each ack carries that requester's echoed word.
  - At least GAP_CYCLES idle cycles between consecutive acks' spi_go_n pulses.
- Wrap: rr_ptr=2, req=4'b0011 -> grant order 0 then 1. Then req=4'b1001 -> grant order 3 then 0.
- Spurious done: spi_done pulsed in IDLE and in GAP -> no ack, rdata unchanged, no state change.
- Reset mid-WAIT: reset pulsed 30 cycles after launch.
  - All outputs return to reset values, spi_go_n=1.
  - The subsequent spi_done is ignored, and the next req[1] is granted normally.
- Timeout (SPI_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=64): engine model never asserts spi_done.
  - ack 64 cycles after WAIT entry, with err=1 and rdata=0.
  - Variant: spi_done coincides with expiry -> err=0 and rdata captured.
